// File: rtl/rr_arb_pkg.sv
// Shared constants and FSM encoding for the round-robin grant controller.
package rr_arb_pkg;

  localparam int unsigned CHANNELS = 8;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned HOLD_W   = 4;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

endpackage

// File: rtl/rr_next_mask.sv
// Round-robin selection: mask requests strictly above the last-granted index,
// wrap to the full request vector when that set is empty, then pick the lowest set bit.
module rr_next_mask
  import rr_arb_pkg::*;
(
  input  logic [CHANNELS-1:0] request_i,
  input  logic [IDX_W-1:0]    last_idx_i,
  output logic [CHANNELS-1:0] pick_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                any_o
);

  logic [CHANNELS-1:0] above;
  logic [CHANNELS-1:0] masked;
  logic [CHANNELS-1:0] elig;
  logic                found;

  // Build the eligibility mask and select its lowest-index set bit.
  always_comb begin
    above = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      above[i] = (IDX_W'(i) > last_idx_i);
    end
    masked = request_i & above;
    elig   = (|masked) ? masked : request_i;

    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (elig[i] && !found) begin
        pick_o[i] = 1'b1;
        idx_o     = IDX_W'(i);
        found     = 1'b1;
      end
    end
    any_o = |request_i;
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller with a per-grant hold limit that only bites
// when another channel is waiting. All outputs are registered.
module rr_grant_ctrl #(
  parameter int unsigned CHANNELS = rr_arb_pkg::CHANNELS,
  parameter int unsigned MAX_HOLD = rr_arb_pkg::MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       scan_in0,
  input  logic                       scan_in1,
  input  logic                       scan_in2,
  input  logic                       scan_in3,
  input  logic                       scan_in4,
  input  logic                       scan_enable,
  input  logic                       test_mode,
  output logic                       scan_out0,
  output logic                       scan_out1,
  output logic                       scan_out2,
  output logic                       scan_out3,
  output logic                       scan_out4,
  input  logic [CHANNELS-1:0]        request,
  output logic [CHANNELS-1:0]        grant,
  output logic                       grant_valid,
  output logic [rr_arb_pkg::IDX_W-1:0] grant_id
);

  import rr_arb_pkg::arb_state_e;
  import rr_arb_pkg::StIdle;
  import rr_arb_pkg::StBusy;
  import rr_arb_pkg::IDX_W;
  import rr_arb_pkg::HOLD_W;

  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

  // DFT pins are stitched later; keep them visible but functionally inert.
  logic unused_dft;
  assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  arb_state_e          state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic                grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [CHANNELS-1:0] pick;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                cur_req;
  logic                others_req;
  logic                take_new;
  logic                go_idle;

  rr_next_mask u_next_mask (
    .request_i  (request),
    .last_idx_i (last_q),
    .pick_o     (pick),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  // Next-state: new grant on idle request, release or timeout; otherwise hold and count.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_d        = last_q;
    hold_cnt_d    = hold_cnt_q;
    take_new      = 1'b0;
    go_idle       = 1'b0;
    cur_req       = request[grant_id_q];
    others_req    = |(request & ~grant_q);

    unique case (state_q)
      StIdle: take_new = pick_any;
      StBusy: begin
        if (!cur_req) begin
          // Holder's bit is already low, so pick can never re-select it.
          if (pick_any) take_new = 1'b1;
          else          go_idle  = 1'b1;
        end else if (hold_cnt_q == HoldLast) begin
          // Saturated: rotate only if someone else is waiting.
          take_new = others_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (take_new) begin
      state_d       = StBusy;
      grant_d       = pick;
      grant_valid_d = 1'b1;
      grant_id_d    = pick_idx;
      last_d        = pick_idx;
      hold_cnt_d    = '0;
    end else if (go_idle) begin
      state_d       = StIdle;
      grant_d       = '0;
      grant_valid_d = 1'b0;
      grant_id_d    = '0;
      hold_cnt_d    = '0;
    end
  end

  // State registers; last index resets to the top so channel 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_q        <= IDX_W'(CHANNELS - 1);
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_q        <= last_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl with hand-computed grant sequences.
module tb_rr_grant_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
  logic       scan_enable, test_mode;
  logic       scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic [7:0] request;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  rr_grant_ctrl #(
    .CHANNELS (8),
    .MAX_HOLD (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (scan_in0),
    .scan_in1    (scan_in1),
    .scan_in2    (scan_in2),
    .scan_in3    (scan_in3),
    .scan_in4    (scan_in4),
    .scan_enable (scan_enable),
    .test_mode   (test_mode),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4),
    .request     (request),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Grant plus its two derived outputs, all from the expected one-hot value.
  task automatic expect_grant(input string tag, input logic [7:0] exp);
    check_val({tag, " grant"}, 32'(grant), 32'(exp));
    check_val({tag, " valid"}, 32'(grant_valid), 32'(exp != 8'h00));
    check_val({tag, " id"}, 32'(grant_id), 32'(onehot_idx(exp)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    request     = 8'h00;
    scan_in0    = 1'b0;
    scan_in1    = 1'b0;
    scan_in2    = 1'b0;
    scan_in3    = 1'b0;
    scan_in4    = 1'b0;
    scan_enable = 1'b0;
    test_mode   = 1'b0;

    #2;
    expect_grant("reset_async", 8'h00);
    check_val("scan_out", 32'({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}), 32'd0);
    step();
    step();
    expect_grant("reset_clocked", 8'h00);
    reset = 1'b1;

    // Idle with no requests.
    for (int c = 0; c < 3; c++) begin
      step();
      expect_grant($sformatf("idle_%0d", c), 8'h00);
    end

    // All request; each holder releases after two cycles.
    request = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      step();
      expect_grant($sformatf("sweep_ch%0d_a", i), 8'(1 << i));
      step();
      expect_grant($sformatf("sweep_ch%0d_b", i), 8'(1 << i));
      request[i] = 1'b0;
    end
    step();
    expect_grant("sweep_end_idle", 8'h00);

    // Wrap-around: last grant ch2, then only ch0/ch1 requesting.
    request = 8'h04;
    step();
    expect_grant("wrap_setup", 8'h04);
    request = 8'h03;
    step();
    expect_grant("wrap_pick", 8'h01);
    request = 8'h00;
    step();
    expect_grant("wrap_idle", 8'h00);

    // Move last index to ch1 so ch0 wins the timeout test first.
    request = 8'h02;
    step();
    expect_grant("prep_ch1", 8'h02);
    request = 8'h00;
    step();
    expect_grant("prep_idle", 8'h00);

    // Timeout rotation between ch0 and ch1.
    request = 8'h03;
    for (int c = 0; c < 16; c++) begin
      step();
      expect_grant($sformatf("timeout_ch0_%0d", c), 8'h01);
    end
    for (int c = 0; c < 16; c++) begin
      step();
      expect_grant($sformatf("timeout_ch1_%0d", c), 8'h02);
    end
    step();
    expect_grant("timeout_back_ch0", 8'h01);
    request = 8'h00;
    step();
    expect_grant("timeout_idle", 8'h00);

    // Lone requester past saturation keeps the grant.
    request = 8'h02;
    for (int c = 0; c < 40; c++) begin
      step();
      expect_grant($sformatf("lone_%0d", c), 8'h02);
    end
    request = 8'h00;
    step();
    expect_grant("lone_idle", 8'h00);

    // Asynchronous reset mid-grant, then priority restarts at ch0.
    request = 8'h10;
    step();
    expect_grant("pre_reset_ch4", 8'h10);
    #2;
    reset = 1'b0;
    #1;
    expect_grant("mid_reset_drop", 8'h00);
    request = 8'hFF;
    step();
    expect_grant("mid_reset_held", 8'h00);
    reset = 1'b1;
    step();
    expect_grant("post_reset_ch0", 8'h01);
    request = 8'hFE;
    step();
    expect_grant("post_reset_ch1", 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
